// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the camera capture block: FSM states,
// RGB565 -> RGB111 bit selection and default geometry.
package cam_pkg;

  localparam int DEF_H_PIXELS = 320;
  localparam int DEF_V_LINES  = 240;
  localparam int DEF_ADDR_W   = 17;

  // Bits kept from RGB565: R and G come from the first byte, B from the second.
  localparam int R_BIT = 7;
  localparam int G_BIT = 2;
  localparam int B_BIT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    IN_VS   = 2'd2,
    ACTIVE  = 2'd3
  } cam_state_e;

  function automatic logic [2:0] rgb565_to_rgb111(input logic [7:0] byte0,
                                                  input logic [7:0] byte1);
    return {byte0[R_BIT], byte0[G_BIT], byte1[B_BIT]};
  endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Camera byte stream plus frame-buffer write port. The master drives the
// camera side, the slave (the capture block) drives the write port.
interface cam_capture_if import cam_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              pclk;
  logic [7:0]        data_in;
  logic              h_ref;
  logic              v_sync;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;

  modport master (
    output pclk, data_in, h_ref, v_sync,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  pclk, data_in, h_ref, v_sync,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/cam_capture_sync_edge.sv
// Two-flop synchronizer with one extra history flop for rise/fall detection.
module sync_edge (
  input  logic clk_50,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign q    = sync_reg;
  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/cam_capture.sv
// Camera capture: samples an RGB565 byte stream on clk_50, decimates 2:1
// vertically and writes RGB111 pixels into a linear frame buffer.
module cam_capture import cam_pkg::*; #(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic         clk_50,
  input  logic         reset_n,
  input  logic         capture_en,
  cam_capture_if.slave cam,
  output logic         frame_done,
  output logic         busy,
  output logic         byte_err
);

  localparam int COL_W     = $clog2(H_PIXELS + 1);
  localparam int LINE_W    = $clog2(2 * V_LINES + 1);
  localparam int SIG_PCLK  = 0;
  localparam int SIG_HREF  = 1;
  localparam int SIG_VSYNC = 2;

  logic [2:0] raw_sig;
  logic [2:0] sync_sig;
  logic [2:0] rise_sig;
  logic [2:0] fall_sig;

  assign raw_sig = {cam.v_sync, cam.h_ref, cam.pclk};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync_edge u_sync (
        .clk_50  (clk_50),
        .reset_n (reset_n),
        .d       (raw_sig[gi]),
        .q       (sync_sig[gi]),
        .rise    (rise_sig[gi]),
        .fall    (fall_sig[gi])
      );
    end
  endgenerate

  logic pclk_rise;
  logic href_q;
  logic href_rise;
  logic href_fall;
  logic vsync_q;
  logic vsync_rise;
  logic vsync_fall;

  assign pclk_rise  = rise_sig[SIG_PCLK];
  assign href_q     = sync_sig[SIG_HREF];
  assign href_rise  = rise_sig[SIG_HREF];
  assign href_fall  = fall_sig[SIG_HREF];
  assign vsync_q    = sync_sig[SIG_VSYNC];
  assign vsync_rise = rise_sig[SIG_VSYNC];
  assign vsync_fall = fall_sig[SIG_VSYNC];

  // Data takes the same two-stage path so it stays aligned with pclk.
  logic [7:0] data_meta_reg;
  logic [7:0] data_sync_reg;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      data_meta_reg <= 8'd0;
      data_sync_reg <= 8'd0;
    end else begin
      data_meta_reg <= cam.data_in;
      data_sync_reg <= data_meta_reg;
    end
  end

  cam_state_e state_reg;
  cam_state_e state_next;
  logic       frame_start;
  logic       frame_end;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (capture_en) state_next = WAIT_VS;
      end
      WAIT_VS: begin
        if (vsync_q) state_next = IN_VS;
      end
      IN_VS: begin
        if (vsync_fall) begin
          state_next  = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        // capture_en is only consulted here, so a dropped request finishes the frame.
        if (vsync_rise) begin
          frame_end  = 1'b1;
          state_next = capture_en ? IN_VS : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [LINE_W-1:0] line_reg;
  logic [COL_W-1:0]  col_reg;
  logic              phase_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic [7:0]        byte0_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [2:0]        wr_data_reg;
  logic              frame_done_reg;
  logic              byte_err_reg;

  logic in_active;
  logic line_in_range;
  logic line_wr;
  logic col_ok;
  logic phase_eff;
  logic byte_stb;

  assign in_active     = (state_reg == ACTIVE);
  assign line_in_range = (line_reg < LINE_W'(2 * V_LINES));
  assign line_wr       = ~line_reg[0] & line_in_range;
  assign col_ok        = (col_reg < COL_W'(H_PIXELS));
  // A byte arriving with the h_ref rise is the first byte of the line.
  assign phase_eff     = href_rise ? 1'b0 : phase_reg;
  assign byte_stb      = in_active & pclk_rise & href_q;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      line_reg       <= '0;
      col_reg        <= '0;
      phase_reg      <= 1'b0;
      row_base_reg   <= '0;
      byte0_reg      <= 8'd0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= 3'd0;
      frame_done_reg <= 1'b0;
      byte_err_reg   <= 1'b0;
    end else begin
      wr_en_reg      <= 1'b0;
      frame_done_reg <= frame_end;
      if (frame_start) begin
        line_reg     <= '0;
        col_reg      <= '0;
        phase_reg    <= 1'b0;
        row_base_reg <= '0;
        byte_err_reg <= 1'b0;
      end else if (in_active) begin
        if (href_rise) begin
          col_reg   <= '0;
          phase_reg <= 1'b0;
        end
        if (byte_stb) begin
          if (!phase_eff) begin
            byte0_reg <= data_sync_reg;
            phase_reg <= 1'b1;
          end else begin
            phase_reg <= 1'b0;
            // Column saturates at H_PIXELS: overlong lines never wrap into the next row.
            if (col_ok) begin
              col_reg <= col_reg + COL_W'(1);
              if (line_wr) begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= row_base_reg + ADDR_W'(col_reg);
                wr_data_reg <= rgb565_to_rgb111(byte0_reg, data_sync_reg);
              end
            end
          end
        end
        if (href_fall) begin
          if (phase_reg) byte_err_reg <= 1'b1;
          if (line_wr) row_base_reg <= row_base_reg + ADDR_W'(H_PIXELS);
          if (line_in_range) line_reg <= line_reg + LINE_W'(1);
          col_reg   <= '0;
          phase_reg <= 1'b0;
        end
      end
    end
  end

  assign cam.wr_en   = wr_en_reg;
  assign cam.wr_addr = wr_addr_reg;
  assign cam.wr_data = wr_data_reg;
  assign frame_done  = frame_done_reg;
  assign byte_err    = byte_err_reg;
  assign busy        = (state_reg != IDLE);

endmodule
